// File: rtl/json_uart_rx.sv
// 8N1 UART receiver plus parser for newline-terminated JSON frames {"T":..,"L":..,"R":..}.
// Define JSON_UART_RX_TIMEOUT_EN to abort partial frames after TIMEOUT_BITS idle bit-times.
module json_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_LEN      = 32,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_in,
  output logic [7:0]  cmd_t,
  output logic [15:0] cmd_l,
  output logic [15:0] cmd_r,
  output logic        cmd_valid,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int LW   = $clog2(MAX_LEN + 1);

  localparam logic [7:0] CH_LBRACE = 8'h7B, CH_RBRACE = 8'h7D, CH_QUOTE = 8'h22;
  localparam logic [7:0] CH_COLON  = 8'h3A, CH_COMMA  = 8'h2C, CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT    = 8'h2E, CH_SPACE  = 8'h20, CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A, CH_T      = 8'h54, CH_L     = 8'h4C;
  localparam logic [7:0] CH_R      = 8'h52;

  localparam logic [2:0] E_FRAME = 3'd1, E_SYNTAX = 3'd2, E_KEY = 3'd3;
  localparam logic [2:0] E_RANGE = 3'd4, E_LEN    = 3'd5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    WAIT_OPEN, KEY_Q1, KEY, KEY_Q2, COLON, SIGN, INT, FRAC, SEP, EOL
  } ps_t;
  typedef enum logic [1:0] {K_T, K_L, K_R} key_t;

  // ---------------- UART receiver ----------------
  logic          uart_meta, uart_sync, armed;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          rx_stb, rx_ferr;

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch like any other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_meta <= 1'b0;
      uart_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking so uart_sync takes the old uart_meta, giving a true two-stage chain.
      uart_meta <= uart_in;
      uart_sync <= uart_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      armed    <= 1'b0;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
      rx_stb   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_stb  <= 1'b0;
      rx_ferr <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          // A low line only counts as a start edge once it has been seen high.
          if (uart_sync) armed <= 1'b1;
          else if (armed) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_state <= uart_sync ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt  <= '0;
            rx_byte <= {uart_sync, rx_byte[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (uart_sync) rx_stb <= 1'b1;
            else begin
              rx_ferr <= 1'b1;
              armed   <= 1'b0;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Frame parser ----------------
  ps_t           state;
  key_t          cur_key, byte_key;
  logic [2:0]    seen, key_mask;
  logic          neg;
  logic [9:0]    int_val;
  logic [1:0]    int_digits, frac_digits;
  logic [6:0]    frac_val, frac_scaled;
  logic [LW-1:0] byte_cnt;
  logic [7:0]    sh_t;
  logic [15:0]   sh_l, sh_r, val_q;
  logic [16:0]   mag;
  logic [3:0]    digit;
  logic          is_digit, is_ws, is_term, byte_is_key, range_bad, keys_done;
  logic          end_err, byte_err, open_frame;
  logic [2:0]    end_code, byte_code;
  ps_t           sep_next;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    is_digit    = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    digit       = rx_byte[3:0];
    is_ws       = (rx_byte == CH_SPACE) || (rx_byte == CH_CR);
    is_term     = is_ws || (rx_byte == CH_COMMA) || (rx_byte == CH_RBRACE);
    byte_is_key = 1'b1;
    byte_key    = K_T;
    case (rx_byte)
      CH_T:    byte_key = K_T;
      CH_L:    byte_key = K_L;
      CH_R:    byte_key = K_R;
      default: byte_is_key = 1'b0;
    endcase
    key_mask    = 3'b001 << cur_key;
    // One fraction digit is tenths, two are hundredths.
    frac_scaled = (frac_digits == 2'd1) ? 7'(frac_val * 10) : frac_val;
    mag         = 17'(int_val * 100) + 17'(frac_scaled);
    val_q       = neg ? -mag[15:0] : mag[15:0];
    range_bad   = (cur_key == K_T) ? (int_val > 10'd255) : (mag > 17'd32767);
    keys_done   = (seen | key_mask) == 3'b111;

    end_err  = 1'b0;
    end_code = E_SYNTAX;
    if (range_bad) begin
      end_err  = 1'b1;
      end_code = E_RANGE;
    end else if (rx_byte == CH_RBRACE && !keys_done) begin
      end_err  = 1'b1;
      end_code = E_KEY;
    end

    sep_next = SEP;
    if (rx_byte == CH_COMMA) sep_next = KEY_Q1;
    else if (rx_byte == CH_RBRACE) sep_next = EOL;

    byte_err  = 1'b0;
    byte_code = E_SYNTAX;
    if (state != WAIT_OPEN && byte_cnt == LW'(MAX_LEN)) begin
      byte_err  = 1'b1;
      byte_code = E_LEN;
    end else begin
      unique case (state)
        WAIT_OPEN: byte_err = 1'b0;
        KEY_Q1:    byte_err = !(is_ws || rx_byte == CH_QUOTE);
        KEY: begin
          if (!byte_is_key) byte_err = 1'b1;
          else if (seen[byte_key]) begin
            byte_err  = 1'b1;
            byte_code = E_KEY;
          end
        end
        KEY_Q2:    byte_err = (rx_byte != CH_QUOTE);
        COLON:     byte_err = !(is_ws || rx_byte == CH_COLON);
        SIGN:      byte_err = !(is_digit || (rx_byte == CH_MINUS && cur_key != K_T));
        INT: begin
          if (is_digit) byte_err = (int_digits == 2'd3);
          else if (rx_byte == CH_DOT) byte_err = (int_digits == 2'd0);
          else if (!is_term || int_digits == 2'd0) byte_err = 1'b1;
          else begin
            byte_err  = end_err;
            byte_code = end_code;
          end
        end
        FRAC: begin
          if (is_digit) byte_err = (frac_digits == 2'd2);
          else if (!is_term) byte_err = 1'b1;
          else begin
            byte_err  = end_err;
            byte_code = end_code;
          end
        end
        SEP: begin
          if (rx_byte == CH_RBRACE && seen != 3'b111) begin
            byte_err  = 1'b1;
            byte_code = E_KEY;
          end else byte_err = !is_term;
        end
        EOL:       byte_err = !(is_ws || rx_byte == CH_LF);
        default:   byte_err = 1'b1;
      endcase
    end
    // A stray '{' both reports the broken frame and opens a new one.
    open_frame = (rx_byte == CH_LBRACE) &&
                 (state == WAIT_OPEN || (byte_err && byte_code == E_SYNTAX));
  end

`ifdef JSON_UART_RX_TIMEOUT_EN
  localparam int          TO_LOAD   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int          TW        = $clog2(TO_LOAD + 1);
  localparam logic [2:0]  E_TIMEOUT = 3'd6;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt <= '0;
    else if (rx_stb) to_cnt <= TW'(TO_LOAD);
    else if (busy && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_OPEN;
      cur_key     <= K_T;
      seen        <= '0;
      neg         <= 1'b0;
      int_val     <= '0;
      int_digits  <= '0;
      frac_val    <= '0;
      frac_digits <= '0;
      byte_cnt    <= '0;
      sh_t        <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      cmd_t       <= '0;
      cmd_l       <= '0;
      cmd_r       <= '0;
      cmd_valid   <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (rx_ferr) begin
        err      <= 1'b1;
        err_code <= E_FRAME;
        state    <= WAIT_OPEN;
        busy     <= 1'b0;
      end else if (rx_stb) begin
        if (open_frame) begin
          state    <= KEY_Q1;
          busy     <= 1'b1;
          seen     <= '0;
          byte_cnt <= LW'(1);
          if (byte_err) begin
            err      <= 1'b1;
            err_code <= byte_code;
          end
        end else if (byte_err) begin
          err      <= 1'b1;
          err_code <= byte_code;
          state    <= WAIT_OPEN;
          busy     <= 1'b0;
        end else if (state != WAIT_OPEN) begin
          byte_cnt <= byte_cnt + 1'b1;
          unique case (state)
            KEY_Q1: if (rx_byte == CH_QUOTE) state <= KEY;
            KEY: begin
              cur_key <= byte_key;
              state   <= KEY_Q2;
            end
            KEY_Q2: state <= COLON;
            COLON: begin
              if (rx_byte == CH_COLON) begin
                state       <= SIGN;
                neg         <= 1'b0;
                int_val     <= '0;
                int_digits  <= '0;
                frac_val    <= '0;
                frac_digits <= '0;
              end
            end
            SIGN: begin
              state <= INT;
              if (is_digit) begin
                int_val    <= 10'(digit);
                int_digits <= 2'd1;
              end else neg <= 1'b1;
            end
            INT, FRAC: begin
              if (is_digit && state == INT) begin
                int_val    <= 10'(int_val * 10 + digit);
                int_digits <= int_digits + 1'b1;
              end else if (is_digit) begin
                frac_val    <= 7'(frac_val * 10 + digit);
                frac_digits <= frac_digits + 1'b1;
              end else if (rx_byte == CH_DOT) begin
                state <= FRAC;
              end else begin
                seen  <= seen | key_mask;
                state <= sep_next;
                case (cur_key)
                  K_T:     sh_t <= int_val[7:0];
                  K_L:     sh_l <= val_q;
                  default: sh_r <= val_q;
                endcase
              end
            end
            SEP: state <= sep_next;
            EOL: begin
              if (rx_byte == CH_LF) begin
                cmd_t     <= sh_t;
                cmd_l     <= sh_l;
                cmd_r     <= sh_r;
                cmd_valid <= 1'b1;
                busy      <= 1'b0;
                state     <= WAIT_OPEN;
              end
            end
            default: state <= WAIT_OPEN;
          endcase
        end
      end
`ifdef JSON_UART_RX_TIMEOUT_EN
      else if (busy && to_cnt == '0) begin
        err      <= 1'b1;
        err_code <= E_TIMEOUT;
        state    <= WAIT_OPEN;
        busy     <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_json_uart_rx.sv
// Self-checking bench for json_uart_rx: table of frames plus hand-written framing, glitch,
// timeout (when JSON_UART_RX_TIMEOUT_EN is defined) and mid-frame reset sequences.
module tb_json_uart_rx;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_in = 1'b1;
  logic [7:0]  cmd_t;
  logic [15:0] cmd_l, cmd_r;
  logic        cmd_valid, err, busy;
  logic [2:0]  err_code;

  json_uart_rx #(.CLKS_PER_BIT(CPB), .MAX_LEN(32), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in),
    .cmd_t(cmd_t), .cmd_l(cmd_l), .cmd_r(cmd_r), .cmd_valid(cmd_valid),
    .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int valid_total = 0;
  int err_total   = 0;
  int n_checks    = 0;
  int n_pass      = 0;

  always @(negedge clk) begin
    if (cmd_valid) valid_total = valid_total + 1;
    if (err)       err_total   = err_total + 1;
  end

  typedef struct {
    string       frame;
    int          n_valid;
    int          n_err;
    logic [2:0]  code;
    logic [7:0]  t;
    logic [15:0] l;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (actual === expected) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic add_vec(input string f, input int nv, input int ne, input logic [2:0] c,
                         input logic [7:0] t, input logic [15:0] l, input logic [15:0] r);
    vec_t v;
    v.frame = f; v.n_valid = nv; v.n_err = ne; v.code = c; v.t = t; v.l = l; v.r = r;
    vecs.push_back(v);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_in = !bad_stop;
    repeat (CPB) @(negedge clk);
    uart_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] t, input logic [15:0] l,
                           input logic [15:0] r);
    check({tag, " cmd_t"}, 32'(cmd_t), 32'(t));
    check({tag, " cmd_l"}, 32'(cmd_l), 32'(l));
    check({tag, " cmd_r"}, 32'(cmd_r), 32'(r));
  endtask

  int v0, e0;

  initial begin
    add_vec("{\"T\":1,\"L\":-0.12,\"R\":0.12}\n",             1, 0, 3'd0, 8'd1,   16'hFFF4, 16'h000C);
    add_vec("{\"T\":1,\"L\":0.5,\"R\":0.05}\n",               1, 0, 3'd0, 8'd1,   16'h0032, 16'h0005);
    add_vec("{\"T\":1,\"L\":0,\"R\":0}\n",                    1, 0, 3'd0, 8'd1,   16'h0000, 16'h0000);
    add_vec("{\"T\":1,\"L\":0.5}\n",                          0, 1, 3'd3, 8'd1,   16'h0000, 16'h0000);
    add_vec("{\"T\":1,\"L\":0.5,{\"T\":2,\"L\":1,\"R\":-1}\n", 1, 1, 3'd2, 8'd2,   16'h0064, 16'hFF9C);
    add_vec("{\"R\":1.25 ,\"T\":255,\"L\":-327.67}\n",        1, 0, 3'd0, 8'd255, 16'h8001, 16'h007D);
    add_vec("{\"T\":1,\"L\":-1.5,\"R\":2.25}       \n",       0, 1, 3'd5, 8'd255, 16'h8001, 16'h007D);
    add_vec("{\"T\":3,\"L\":327.68,\"R\":0}\n",               0, 1, 3'd4, 8'd255, 16'h8001, 16'h007D);
    add_vec("{\"T\":3,\"L\":1.234,\"R\":0}\n",                0, 1, 3'd2, 8'd255, 16'h8001, 16'h007D);
    add_vec("{\"T\":-1,\"L\":0,\"R\":0}\n",                   0, 1, 3'd2, 8'd255, 16'h8001, 16'h007D);
    add_vec("{\"T\":1,\"T\":2,\"L\":0,\"R\":0}\n",            0, 1, 3'd3, 8'd255, 16'h8001, 16'h007D);
    add_vec("{\"L\":-0.5,\"R\":9,\"T\":7.9}\n",               1, 0, 3'd0, 8'd7,   16'hFFCE, 16'h0384);
    add_vec("xx{\"T\":0,\"L\":.5,\"R\":0}\n",                 0, 1, 3'd2, 8'd7,   16'hFFCE, 16'h0384);
    add_vec("{\"T\":10,\"L\":1.,\"R\":-0.01}\n",              1, 0, 3'd0, 8'd10,  16'h0064, 16'hFFFF);

    // Reset state
    repeat (4) @(negedge clk);
    check("reset cmd_t", 32'(cmd_t), 32'd0);
    check("reset cmd_l", 32'(cmd_l), 32'd0);
    check("reset cmd_r", 32'(cmd_r), 32'd0);
    check("reset cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    foreach (vecs[i]) begin
      v0 = valid_total;
      e0 = err_total;
      send_frame(vecs[i].frame);
      repeat (3 * CPB) @(negedge clk);
      check($sformatf("vec%0d valid pulses", i), 32'(valid_total - v0), 32'(vecs[i].n_valid));
      check($sformatf("vec%0d err pulses", i), 32'(err_total - e0), 32'(vecs[i].n_err));
      if (vecs[i].n_err != 0)
        check($sformatf("vec%0d err_code", i), 32'(err_code), 32'(vecs[i].code));
      check_cmd($sformatf("vec%0d", i), vecs[i].t, vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
    end

    // Stop bit forced low mid-frame: frame aborted, next frame decodes
    v0 = valid_total;
    e0 = err_total;
    send_frame("{\"T\":5,");
    send_byte(8'h55, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("ferr err_code", 32'(err_code), 32'd1);
    check("ferr busy", 32'(busy), 32'd0);
    send_frame("\"L\":1,\"R\":1}\n");
    send_frame("{\"T\":5,\"L\":1,\"R\":1}\n");
    repeat (3 * CPB) @(negedge clk);
    check("ferr err pulses", 32'(err_total - e0), 32'd1);
    check("ferr valid pulses", 32'(valid_total - v0), 32'd1);
    check_cmd("ferr", 8'd5, 16'h0064, 16'h0064);

    // Short low glitch on an idle line is rejected silently
    v0 = valid_total;
    e0 = err_total;
    @(negedge clk);
    uart_in = 1'b0;
    repeat (2) @(negedge clk);
    uart_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_frame("{\"T\":6,\"L\":-2,\"R\":3}\n");
    repeat (3 * CPB) @(negedge clk);
    check("glitch err pulses", 32'(err_total - e0), 32'd0);
    check("glitch valid pulses", 32'(valid_total - v0), 32'd1);
    check_cmd("glitch", 8'd6, 16'hFF38, 16'h012C);

`ifdef JSON_UART_RX_TIMEOUT_EN
    e0 = err_total;
    send_frame("{\"T\":1");
    repeat (25 * CPB) @(negedge clk);
    check("timeout err pulses", 32'(err_total - e0), 32'd1);
    check("timeout err_code", 32'(err_code), 32'd6);
    check("timeout busy", 32'(busy), 32'd0);
`endif

    // Reset in the middle of a frame
    send_frame("{\"T\":1");
    check("midframe busy", 32'(busy), 32'd1);
    e0 = err_total;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset cmd_t", 32'(cmd_t), 32'd0);
    check("midreset cmd_l", 32'(cmd_l), 32'd0);
    check("midreset cmd_r", 32'(cmd_r), 32'd0);
    check("midreset err_code", 32'(err_code), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("midreset err pulses", 32'(err_total - e0), 32'd0);
    v0 = valid_total;
    send_frame("{\"T\":9,\"L\":-1,\"R\":1}\n");
    repeat (3 * CPB) @(negedge clk);
    check("post-reset valid pulses", 32'(valid_total - v0), 32'd1);
    check_cmd("post-reset", 8'd9, 16'hFF9C, 16'h0064);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/json_uart_rx.md
Name: json_uart_rx

Overview:
- Receive end of the rover command link.
- Deserialises 8N1 UART bytes from a GPIO pin and parses newline-terminated JSON frames of the form {"T":1,"L":-0.12,"R":0.5}.
- Presents T, L and R as integers, with L and R in signed hundredths, plus a one-cycle valid strobe.
- Sits between the board GPIO input and the motor/status logic; it is the counterpart of the JSON command transmitter.

Parameters:
- CLKS_PER_BIT, 434, clocks per UART bit (115200 baud at 50 MHz).
- MAX_LEN, 32, maximum bytes per frame, counted from '{' to '\n' inclusive.
- TIMEOUT_BITS, 20, idle bit-times before a partial frame is aborted (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- uart_in  in  1  UART RX line; idles high; asynchronous to clk.
- cmd_t  out  8  T value, unsigned, 0..255.
- cmd_l  out  16  L value, signed two's complement, in hundredths.
- cmd_r  out  16  R value, signed two's complement, in hundredths.
- cmd_valid  out  1  one-cycle pulse when cmd_t/cmd_l/cmd_r update.
- err  out  1  one-cycle pulse on any error.
- err_code  out  3  cause of the last error; held until the next error.
- busy  out  1  high while a frame is partially received.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs go to 0.
  - RX returns to IDLE; parser returns to WAIT_OPEN.
  - After release, start detection is armed only once the synchronised line has been seen high.
  - A frame in progress at reset is discarded with no err pulse.
- UART RX:
  - uart_in passes through a 2-FF synchroniser.
  - RX states: IDLE -> START -> DATA -> STOP.
  - START: triggered by a falling edge. The line is resampled at CLKS_PER_BIT/2; if high, the event is a glitch and RX returns to IDLE.
  - DATA: 8 bits, LSB first, each sampled every CLKS_PER_BIT.
  - STOP: if the stop sample is 1, one internal byte strobe is produced. If it is 0, the byte is dropped, err is pulsed with err_code=1, the parser aborts its frame, and RX waits for the line to go high before re-arming.
- Parser states:
  - WAIT_OPEN, KEY_Q1, KEY, KEY_Q2, COLON, SIGN, INT, FRAC, SEP, EOL.
  - WAIT_OPEN discards every byte except '{'.
  - Grammar: '{' then one or more "K":value pairs separated by ',', then '}' then '\n'. K is one of T, L, R.
  - Bytes 0x20 (space) and 0x0D (CR) are ignored in KEY_Q1, COLON, SEP and EOL only.
- Values:
  - Optional '-' (rejected for T), then 1-3 integer digits, then an optional '.' followed by 0-2 fraction digits.
  - Result = int*100 + frac, where one fraction digit counts as tens: ".5" -> 50, ".05" -> 5, ".12" -> 12.
  - A leading '-' negates the result.
  - T ignores any fraction part and must be <= 255.
  - L/R magnitude above 32767 -> err_code=4.
  - Empty digits, or more than 2 fraction digits -> err_code=2.
- Keys:
  - Each of T, L and R must appear exactly once, in any order.
  - A duplicate key, or a missing key when '}' arrives -> err_code=3.
- Frame completion:
  - Parsed values are held in shadow registers.
  - On the '\n' after '}', the shadow values are copied to cmd_* and cmd_valid is pulsed one clk after the '\n' byte strobe. Updates are atomic; outputs otherwise hold.
- Errors:
  - Any unexpected byte -> err_code=2; pulse err; parser returns to WAIT_OPEN.
  - If the offending byte is '{', it starts a new frame immediately.
  - Byte count exceeding MAX_LEN -> err_code=5 and abort.
  - cmd_* never change on an error.
- busy is high from '{' until frame completion or abort.
- Only one byte can be in flight at a time, so error and valid strobes can never coincide.

Optional Feature:
- Macro: JSON_UART_RX_TIMEOUT_EN.
- Defined:
  - A counter reloads to TIMEOUT_BITS*CLKS_PER_BIT on every byte strobe while busy.
  - When it reaches 0 with busy high: abort the frame, pulse err, set err_code=6.
- Undefined: the counter is absent, and a partial frame waits indefinitely for more bytes.

Test Plan:
- Send {"T":1,"L":-0.12,"R":0.12}\n at CLKS_PER_BIT=434 -> one cmd_valid; cmd_t=1, cmd_l=-12 (0xFFF4), cmd_r=12; err never asserted.
- Send {"T":1,"L":0.5,"R":0.05}\n, then {"T":1,"L":0,"R":0}\n -> first frame gives cmd_l=50, cmd_r=5; second gives cmd_l=0, cmd_r=0; exactly two cmd_valid pulses.
- Send {"T":1,"L":0.5}\n -> err with err_code=3; no cmd_valid; cmd_* keep their prior values.
- Send {"T":1,"L":0.5,{"T":2,"L":1,"R":-1}\n -> err with err_code=2 at the second '{'; then cmd_valid with cmd_t=2, cmd_l=100, cmd_r=-100.
- Send a byte with its stop bit forced low, then a valid frame -> err with err_code=1; the following frame decodes correctly.
- With JSON_UART_RX_TIMEOUT_EN defined, send {"T":1 then hold the line idle for 20 bit-times -> err with err_code=6 and busy low. Assert rst_n low mid-frame -> all outputs 0 and no err pulse.
